interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: minimum stall cycles for in-flight instructions to leave the pipeline.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port int_req, input, 1: external interrupt request, level input; a 0->1 transition is the event.
REQ-005 SHALL have port int_index, input, 3: IVT entry selector, captured with the event.
REQ-006 SHALL have port cur_pc, input, 32: PC of the next instruction to fetch.
REQ-007 SHALL have port flags, input, 4: ALU flag register, captured with the event.
REQ-008 SHALL have port pipe_busy, input, 1: high while any multi-cycle operation or memory access is in flight.
REQ-009 SHALL have port mem_ack, input, 1: stack write accepted this cycle.
REQ-010 SHALL have port fetch_stall, output, 1: disables the fetch/decode buffer enable.
REQ-011 SHALL have port flush, output, 1: one-cycle bubble insertion into the decode buffer.
REQ-012 SHALL have port pc_select, output, 2: fetch PC source, 00 = sequential, 01 = IVT; 10 and 11 are never driven.
REQ-013 SHALL have port ivt_index, output, 3: IVT entry selector for fetch.
REQ-014 SHALL have port push_valid, output, 1: stack write request.
REQ-015 SHALL have port push_data, output, 16: stack write data.
REQ-016 SHALL have port int_active, output, 1: high in every state except IDLE.
REQ-017 SHALL have port int_ack, output, 1: one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, DRAIN, PUSH_LO, PUSH_HI, PUSH_FLG, VECTOR, RESUME.
REQ-019 SHALL register int_req every cycle and detect an event when the current sample is 1 and the previous sample is 0.
REQ-020 SHALL set a pending bit on an event in any non-IDLE state, and clear it when the event is accepted.
REQ-021 SHALL, in IDLE with an event or the pending bit set, capture cur_pc, flags and int_index into saved registers, assert flush for that one cycle, and go to DRAIN.
REQ-022 SHALL remain in DRAIN for at least DRAIN_CYCLES cycles and until pipe_busy is sampled 0, then go to PUSH_LO.
REQ-023 SHALL hold fetch_stall=1 in DRAIN, PUSH_LO, PUSH_HI and PUSH_FLG, and hold it 0 otherwise.
REQ-024 SHALL, in PUSH_LO, PUSH_HI and PUSH_FLG, assert push_valid with push_data = saved_pc[15:0], saved_pc[31:16] and {12'b0, saved_flags} respectively.
REQ-025 SHALL hold each push state and its push_data stable until mem_ack=1, then advance on that edge.
REQ-026 SHALL ignore mem_ack outside the push states.
REQ-027 SHALL, in VECTOR, drive pc_select=01 and ivt_index=saved_index for exactly one cycle, then go to RESUME.
REQ-028 SHALL, in RESUME, pulse int_ack=1 for one cycle, then go to IDLE.
REQ-029 SHALL drive pc_select=00, push_valid=0 and push_data=0 in every state not listed above as driving them.
REQ-030 SHALL complete the sequence in DRAIN_CYCLES+6 cycles from event to IDLE with mem_ack=1 and pipe_busy=0 (9 cycles at the default).
REQ-031 SHALL never nest: int_req activity during a sequence only sets the pending bit; at most one event is held pending.

Reset
REQ-032 SHALL, while rst=0, force IDLE, clear the pending bit, the int_req sample and the saved registers, and drive every output to 0, independently of clk.
REQ-033 SHALL, on reset assertion mid-sequence, abandon the sequence immediately with no further push_valid or int_ack.
REQ-034 SHALL not treat int_req=1 at reset release as an event.

Verification
REQ-035 Bench SHALL cover a basic interrupt: int_req 0->1, index=5, pc=0x0001_2340, flags=0xA, mem_ack=1, pipe_busy=0 -> pushes 0x2340, 0x0001, 0x000A; VECTOR with ivt_index=5; int_ack 9 cycles after the event.
REQ-036 Bench SHALL cover a slow stack: mem_ack held 0 for 4 cycles in PUSH_HI -> push_data holds 0x0001 and fetch_stall holds 1; ack arrives 4 cycles later.
REQ-037 Bench SHALL cover a busy pipeline: pipe_busy=1 for 6 cycles after the event -> DRAIN lasts 6 cycles and PUSH_LO starts the cycle after pipe_busy falls.
REQ-038 Bench SHALL cover a pending event: second int_req edge during PUSH_HI -> IDLE for one cycle, then a new DRAIN with flush=1; a third edge in the same sequence is lost.
REQ-039 Bench SHALL cover reset during PUSH_LO: rst=0 asynchronously -> all outputs 0 within the same cycle and state IDLE; with int_req held 1 through release, no sequence starts.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - interrupt entry sequencer: drain pipeline, push context, vector, acknowledge
module interrupt_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_req,
    input  logic [2:0]  int_index,
    input  logic [31:0] cur_pc,
    input  logic [3:0]  flags,
    input  logic        pipe_busy,
    input  logic        mem_ack,
    output logic        fetch_stall,
    output logic        flush,
    output logic [1:0]  pc_select,
    output logic [2:0]  ivt_index,
    output logic        push_valid,
    output logic [15:0] push_data,
    output logic        int_active,
    output logic        int_ack
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_LO,
        PUSH_HI,
        PUSH_FLG,
        VECTOR,
        RESUME
    } ctrlState;

    ctrlState         state;
    ctrlState         nextState;
    logic             reqSample;
    logic             reqPrev;
    logic             sampleValid;
    logic             pending;
    logic             reqEvent;
    logic             accept;
    logic             drainDone;
    logic [CNT_W-1:0] drainCnt;
    logic [31:0]      savedPc;
    logic [3:0]       savedFlags;
    logic [2:0]       savedIndex;

    // The first sample after reset also seeds the previous sample, so a request
    // already high at reset release never looks like a rising edge.
    assign reqEvent  = reqSample & ~reqPrev;
    assign accept    = (state == IDLE) && (reqEvent || pending);
    assign drainDone = (32'(drainCnt) + 32'd1) >= 32'(DRAIN_CYCLES);

    // Two-stage sampling of the level request for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reqSample   <= 1'b0;
            reqPrev     <= 1'b0;
            sampleValid <= 1'b0;
        end else begin
            reqSample   <= int_req;
            reqPrev     <= sampleValid ? reqSample : int_req;
            sampleValid <= 1'b1;
        end
    end

    // Single-deep pending flag: edges during a sequence collapse into one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b0;
        end else if (reqEvent && (state != IDLE)) begin
            pending <= 1'b1;
        end
    end

    // Context captured at the moment the interrupt is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            savedPc    <= 32'h0;
            savedFlags <= 4'h0;
            savedIndex <= 3'h0;
        end else if (accept) begin
            savedPc    <= cur_pc;
            savedFlags <= flags;
            savedIndex <= int_index;
        end
    end

    // Counts cycles spent in DRAIN, saturating once the minimum is met
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drainCnt <= '0;
        end else if (state != DRAIN) begin
            drainCnt <= '0;
        end else if (!drainDone) begin
            drainCnt <= drainCnt + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode
    always_comb begin
        nextState   = state;
        fetch_stall = 1'b0;
        flush       = 1'b0;
        pc_select   = 2'b00;
        ivt_index   = 3'd0;
        push_valid  = 1'b0;
        push_data   = 16'h0;
        int_active  = 1'b1;
        int_ack     = 1'b0;
        case (state)
            IDLE: begin
                int_active = 1'b0;
                if (accept) begin
                    flush     = 1'b1;
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                fetch_stall = 1'b1;
                if (drainDone && !pipe_busy) begin
                    nextState = PUSH_LO;
                end
            end
            PUSH_LO: begin
                fetch_stall = 1'b1;
                push_valid  = 1'b1;
                push_data   = savedPc[15:0];
                if (mem_ack) begin
                    nextState = PUSH_HI;
                end
            end
            PUSH_HI: begin
                fetch_stall = 1'b1;
                push_valid  = 1'b1;
                push_data   = savedPc[31:16];
                if (mem_ack) begin
                    nextState = PUSH_FLG;
                end
            end
            PUSH_FLG: begin
                fetch_stall = 1'b1;
                push_valid  = 1'b1;
                push_data   = {12'h0, savedFlags};
                if (mem_ack) begin
                    nextState = VECTOR;
                end
            end
            VECTOR: begin
                pc_select = 2'b01;
                ivt_index = savedIndex;
                nextState = RESUME;
            end
            RESUME: begin
                int_ack   = 1'b1;
                nextState = IDLE;
            end
            default: begin
                int_active = 1'b0;
                nextState  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - randomized and directed checks of interrupt_ctrl against a phase-level model
`timescale 1ns/1ps
module tb_interrupt_ctrl;

    localparam int DC   = 3;
    localparam int MAXN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_req;
    logic [2:0]  int_index;
    logic [31:0] cur_pc;
    logic [3:0]  flags;
    logic        pipe_busy;
    logic        mem_ack;
    logic        fetch_stall;
    logic        flush;
    logic [1:0]  pc_select;
    logic [2:0]  ivt_index;
    logic        push_valid;
    logic [15:0] push_data;
    logic        int_active;
    logic        int_ack;

    int tests  = 0;
    int failed = 0;
    int nCyc;

    logic        reqA   [0:MAXN-1];
    logic        busyA  [0:MAXN-1];
    logic        ackA   [0:MAXN-1];
    logic [31:0] pcA    [0:MAXN-1];
    logic [3:0]  flagsA [0:MAXN-1];
    logic [2:0]  idxA   [0:MAXN-1];
    logic [25:0] expV   [0:MAXN-1];
    logic [25:0] obsV   [0:MAXN-1];

    interrupt_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .int_req     (int_req),
        .int_index   (int_index),
        .cur_pc      (cur_pc),
        .flags       (flags),
        .pipe_busy   (pipe_busy),
        .mem_ack     (mem_ack),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .pc_select   (pc_select),
        .ivt_index   (ivt_index),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .int_active  (int_active),
        .int_ack     (int_ack)
    );

    always #5 clk = ~clk;

    // Layout: [25]flush [24]stall [23:22]pc_select [21:19]ivt [18]push_valid [17:2]push_data [1]active [0]ack
    function automatic logic [25:0] pack(input logic fl, input logic st, input logic [1:0] ps,
                                         input logic [2:0] iv, input logic pv, input logic [15:0] pd,
                                         input logic ac, input logic ak);
        return {fl, st, ps, iv, pv, pd, ac, ak};
    endfunction

    function automatic logic [25:0] outNow();
        return pack(flush, fetch_stall, pc_select, ivt_index, push_valid, push_data, int_active, int_ack);
    endfunction

    task automatic setDefault(input int n, input logic [31:0] pc, input logic [3:0] fl, input logic [2:0] idx);
        nCyc = n;
        for (int k = 0; k < MAXN; k++) begin
            reqA[k]   = 1'b0;
            busyA[k]  = 1'b0;
            ackA[k]   = 1'b1;
            pcA[k]    = pc;
            flagsA[k] = fl;
            idxA[k]   = idx;
        end
    endtask

    task automatic doReset();
        rst       = 1'b0;
        int_req   = 1'b0;
        pipe_busy = 1'b0;
        mem_ack   = 1'b0;
        cur_pc    = 32'h0;
        flags     = 4'h0;
        int_index = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic runStim();
        for (int k = 0; k < nCyc; k++) begin
            int_req   = reqA[k];
            pipe_busy = busyA[k];
            mem_ack   = ackA[k];
            cur_pc    = pcA[k];
            flags     = flagsA[k];
            int_index = idxA[k];
            @(negedge clk);
            obsV[k] = outNow();
            @(posedge clk);
            #1;
        end
    endtask

    // Phase-level reference: locate each accepted event, then derive the span of every
    // phase from the first cycle whose busy/ack input lets it end.
    task automatic buildExpected();
        logic ev [0:MAXN-1];
        logic pend;
        int k, t, c, a1, a2, a3;
        for (int j = 0; j < MAXN; j++) begin
            expV[j] = '0;
            if (j >= 2) ev[j] = reqA[j-1] && !reqA[j-2];
            else        ev[j] = 1'b0;
        end
        k = 0;
        pend = 1'b0;
        while (k < nCyc) begin
            if (ev[k] || pend) begin
                t = k;
                pend = 1'b0;
                expV[t] = pack(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
                c = t + DC;
                while (c < nCyc && busyA[c]) c++;
                a1 = c + 1;
                while (a1 < nCyc && !ackA[a1]) a1++;
                a2 = a1 + 1;
                while (a2 < nCyc && !ackA[a2]) a2++;
                a3 = a2 + 1;
                while (a3 < nCyc && !ackA[a3]) a3++;
                for (int j = t + 1; j < nCyc && j <= a3 + 2; j++) begin
                    if (j <= c)
                        expV[j] = pack(1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 16'h0, 1'b1, 1'b0);
                    else if (j <= a1)
                        expV[j] = pack(1'b0, 1'b1, 2'b00, 3'd0, 1'b1, pcA[t][15:0], 1'b1, 1'b0);
                    else if (j <= a2)
                        expV[j] = pack(1'b0, 1'b1, 2'b00, 3'd0, 1'b1, pcA[t][31:16], 1'b1, 1'b0);
                    else if (j <= a3)
                        expV[j] = pack(1'b0, 1'b1, 2'b00, 3'd0, 1'b1, {12'h0, flagsA[t]}, 1'b1, 1'b0);
                    else if (j == a3 + 1)
                        expV[j] = pack(1'b0, 1'b0, 2'b01, idxA[t], 1'b0, 16'h0, 1'b1, 1'b0);
                    else
                        expV[j] = pack(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 16'h0, 1'b1, 1'b1);
                    if (ev[j]) pend = 1'b1;
                end
                k = a3 + 3;
            end else begin
                k++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int_req   = 1'(i % 2);
            pipe_busy = 1'($urandom_range(0, 1));
            mem_ack   = 1'b1;
            cur_pc    = $urandom;
            flags     = 4'($urandom_range(0, 15));
            int_index = 3'($urandom_range(0, 7));
            @(negedge clk);
            tests++;
            if (outNow() !== 26'h0) begin
                failed++;
                $display("FAIL reset_outputs iter%0d got %h want 0", i, outNow());
            end
        end
    endtask

    task automatic test_basic();
        int ackCyc;
        int nPush;
        logic [15:0] pushes [0:2];
        logic [15:0] wantPush [0:2];
        wantPush[0] = 16'h2340;
        wantPush[1] = 16'h0001;
        wantPush[2] = 16'h000A;
        setDefault(24, 32'h0001_2340, 4'hA, 3'd5);
        for (int k = 3; k < 24; k++) reqA[k] = 1'b1;
        doReset();
        runStim();
        buildExpected();
        ackCyc = -1;
        nPush = 0;
        for (int k = 0; k < nCyc; k++) begin
            tests++;
            if (obsV[k] !== expV[k]) begin
                failed++;
                $display("FAIL basic cyc%0d got %h want %h", k, obsV[k], expV[k]);
            end
            if (obsV[k][0] && ackCyc < 0) ackCyc = k;
            if (obsV[k][18] && nPush < 3) begin
                pushes[nPush] = obsV[k][17:2];
                nPush++;
            end
            if (obsV[k][23:22] == 2'b01) begin
                tests++;
                if (obsV[k][21:19] !== 3'd5) begin
                    failed++;
                    $display("FAIL basic_ivt got %0d want 5", obsV[k][21:19]);
                end
            end
        end
        tests++;
        if (ackCyc - 3 != 9) begin
            failed++;
            $display("FAIL basic_ack_latency got %0d want 9", ackCyc - 3);
        end
        tests++;
        if (nPush != 3) begin
            failed++;
            $display("FAIL basic_push_count got %0d want 3", nPush);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (pushes[i] !== wantPush[i]) begin
                    failed++;
                    $display("FAIL basic_push%0d got %h want %h", i, pushes[i], wantPush[i]);
                end
            end
        end
    endtask

    task automatic test_slow_stack();
        int hold;
        setDefault(28, 32'h0001_2340, 4'hA, 3'd5);
        for (int k = 3; k < 28; k++) reqA[k] = 1'b1;
        for (int k = 9; k <= 12; k++) ackA[k] = 1'b0;
        doReset();
        runStim();
        buildExpected();
        hold = 0;
        for (int k = 0; k < nCyc; k++) begin
            tests++;
            if (obsV[k] !== expV[k]) begin
                failed++;
                $display("FAIL slow_stack cyc%0d got %h want %h", k, obsV[k], expV[k]);
            end
            if (obsV[k][18] && obsV[k][24] && obsV[k][17:2] == 16'h0001) hold++;
        end
        tests++;
        if (hold != 5) begin
            failed++;
            $display("FAIL slow_stack_hold got %0d want 5", hold);
        end
    endtask

    task automatic test_busy_pipe();
        int drainLen;
        setDefault(28, 32'h0001_2340, 4'hA, 3'd5);
        for (int k = 3; k < 28; k++) reqA[k] = 1'b1;
        for (int k = 4; k <= 9; k++) busyA[k] = 1'b1;
        doReset();
        runStim();
        buildExpected();
        drainLen = 0;
        for (int k = 0; k < nCyc; k++) begin
            tests++;
            if (obsV[k] !== expV[k]) begin
                failed++;
                $display("FAIL busy_pipe cyc%0d got %h want %h", k, obsV[k], expV[k]);
            end
            if (obsV[k][24] && !obsV[k][18]) drainLen++;
        end
        tests++;
        if (drainLen != 6) begin
            failed++;
            $display("FAIL busy_drain_len got %0d want 6", drainLen);
        end
        tests++;
        if (!(obsV[11][18] && obsV[11][17:2] == 16'h2340 && !obsV[10][18])) begin
            failed++;
            $display("FAIL busy_push_lo_start got %h/%h want push of 2340 first at cycle 11", obsV[10], obsV[11]);
        end
    endtask

    task automatic test_back_to_back();
        int nFlush;
        setDefault(40, 32'h0, 4'h3, 3'd2);
        for (int k = 0; k < 40; k++) pcA[k] = 32'h1000_0000 + 32'(k);
        for (int k = 3; k <= 5; k++) reqA[k] = 1'b1;
        reqA[8] = 1'b1;
        for (int k = 10; k < 40; k++) reqA[k] = 1'b1;
        doReset();
        runStim();
        buildExpected();
        nFlush = 0;
        for (int k = 0; k < nCyc; k++) begin
            tests++;
            if (obsV[k] !== expV[k]) begin
                failed++;
                $display("FAIL pending cyc%0d got %h want %h", k, obsV[k], expV[k]);
            end
            if (obsV[k][25]) nFlush++;
        end
        tests++;
        if (nFlush != 2) begin
            failed++;
            $display("FAIL pending_flush_count got %0d want 2", nFlush);
        end
        tests++;
        if (!(obsV[13][25] && !obsV[13][1] && obsV[14][24])) begin
            failed++;
            $display("FAIL pending_idle_gap got %h/%h want flush in idle cycle 13 then drain", obsV[13], obsV[14]);
        end
    endtask

    task automatic test_random();
        logic lvl;
        for (int it = 0; it < 20; it++) begin
            setDefault(MAXN, 32'h0, 4'h0, 3'd0);
            lvl = 1'($urandom_range(0, 1));
            for (int k = 0; k < MAXN; k++) begin
                if ($urandom_range(0, 5) == 0) lvl = ~lvl;
                reqA[k]   = lvl;
                busyA[k]  = ($urandom_range(0, 3) == 0);
                ackA[k]   = ($urandom_range(0, 3) != 0);
                pcA[k]    = $urandom;
                flagsA[k] = 4'($urandom_range(0, 15));
                idxA[k]   = 3'($urandom_range(0, 7));
            end
            doReset();
            runStim();
            buildExpected();
            for (int k = 0; k < nCyc; k++) begin
                tests++;
                if (obsV[k] !== expV[k]) begin
                    failed++;
                    $display("FAIL random it%0d cyc%0d got %h want %h", it, k, obsV[k], expV[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int k = 0; k <= 8; k++) begin
            int_req   = (k >= 3);
            pipe_busy = 1'b0;
            mem_ack   = 1'b0;
            cur_pc    = 32'h0001_2340;
            flags     = 4'hA;
            int_index = 3'd5;
            @(negedge clk);
            if (k < 8) begin
                @(posedge clk);
                #1;
            end
        end
        tests++;
        if (!(push_valid === 1'b1 && push_data === 16'h2340)) begin
            failed++;
            $display("FAIL midreset_setup got valid=%b data=%h want 1/2340", push_valid, push_data);
        end
        rst = 1'b0;
        mem_ack = 1'b1;
        #1;
        tests++;
        if (outNow() !== 26'h0) begin
            failed++;
            $display("FAIL midreset_async got %h want 0", outNow());
        end
        @(posedge clk);
        #1;
        tests++;
        if (outNow() !== 26'h0) begin
            failed++;
            $display("FAIL midreset_held got %h want 0", outNow());
        end
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests++;
            if (outNow() !== 26'h0) begin
                failed++;
                $display("FAIL midreset_release cyc%0d got %h want 0", k, outNow());
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_stack();
        test_busy_pipe();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
